// File: rtl/alu_defs.sv
// Shared ALU definitions: word type, opcodes, responder state encoding.
// Imported by alu, alu_responder and the bench.
package alu_defs;

  localparam int WORD = 16;

  typedef logic [WORD-1:0] word_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_PASY = 5'd10;
  // Reserved for the responder's iterative multiply; alu never decodes it.
  localparam logic [4:0] OP_MUL  = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU. Ports: op (5-bit opcode), x, y operands,
// z result. Undecoded opcodes (including OP_MUL) return zero.
module alu
  import alu_defs::*;
(
  input  logic [4:0] op,
  input  word_t      x,
  input  word_t      y,
  output word_t      z
);

  always_comb begin
    z = '0;
    unique case (1'b1)
      (op == OP_ADD):  z = x + y;
      (op == OP_SUB):  z = x - y;
      (op == OP_AND):  z = x & y;
      (op == OP_OR):   z = x | y;
      (op == OP_XOR):  z = x ^ y;
      (op == OP_SHL):  z = x << y[3:0];
      (op == OP_SHR):  z = x >> y[3:0];
      (op == OP_SRA):  z = word_t'($signed(x) >>> y[3:0]);
      (op == OP_SLT):  z = {15'd0, $signed(x) < $signed(y)};
      (op == OP_SLTU): z = {15'd0, x < y};
      (op == OP_PASY): z = y;
      default:         z = '0;
    endcase
  end

endmodule

// File: rtl/alu_responder.sv
// Valid/ready ALU responder: single-cycle ops via alu, OP_MUL by shift-add.
// Ports: req_* request channel, resp_* registered result, ops_done count.
module alu_responder
  import alu_defs::*;
#(
  parameter int MUL_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  word_t       req_x,
  input  word_t       req_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output word_t       resp_z,
  output logic [15:0] ops_done
);

  localparam int SW = $clog2(MUL_STEPS);

  state_t        state;
  state_t        state_nxt;
  word_t         alu_z;
  word_t         mcand;
  word_t         mplier;
  word_t         acc;
  word_t         acc_sum;
  logic [SW-1:0] step;
  logic          accept;
  logic          is_mul;
  logic          last;
  logic          hs;

  alu u_alu (
    .op (req_op),
    .x  (req_x),
    .y  (req_y),
    .z  (alu_z)
  );

  assign accept  = req_valid & req_ready;
  assign is_mul  = req_op == OP_MUL;
  assign hs      = resp_valid & resp_ready;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign last    = step == SW'(MUL_STEPS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (accept) state_nxt = is_mul ? ST_MUL : ST_RESP;
      end
      (state == ST_MUL): begin
        if (last) state_nxt = ST_RESP;
      end
      (state == ST_RESP): begin
        if (accept)          state_nxt = is_mul ? ST_MUL : ST_RESP;
        else if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // In RESP the slot frees on the same edge the result is taken.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): req_ready = 1'b1;
      (state == ST_RESP): begin
        req_ready  = resp_ready;
        resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_z <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= req_x;
        mplier <= req_y;
        acc    <= '0;
        step   <= '0;
      end else begin
        resp_z <= alu_z;
      end
    end else if (state == ST_MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 1'b1;
      if (last) resp_z <= acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ops_done <= '0;
    else if (hs) ops_done <= ops_done + 16'd1;
  end

endmodule
